// File: rtl/seq_mult_pkg.sv
// Shared types and defaults for the sequential shift-add multiplier.
package seq_mult_pkg;

  localparam int BITS_DEFAULT = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_mult_dp.sv
// Shift-add datapath: one partial product per step, last one negated in signed mode.
module seq_mult_dp
  import seq_mult_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic              clk,
  input  logic              load_i,
  input  logic              step_i,
  input  logic              last_i,
  input  logic              sgn_i,
  input  logic [BITS-1:0]   a_i,
  input  logic [BITS-1:0]   b_i,
  output logic [2*BITS-1:0] prod_next_o
);

  logic [2*BITS-1:0] mcand_q;
  logic [2*BITS-1:0] acc_q;
  logic [2*BITS-1:0] pp;
  logic [2*BITS-1:0] sum_d;
  logic [BITS-1:0]   mplier_q;
  logic              sgn_q;

  function automatic logic [2*BITS-1:0] extend(input logic [BITS-1:0] v, input logic sgn);
    logic signed [BITS-1:0] vs;
    vs = v;
    extend = {{BITS{sgn & vs[BITS-1]}}, v};
  endfunction

  // The multiplier MSB carries weight -2^(BITS-1) when signed, so subtract it.
  always_comb begin
    pp = mplier_q[0] ? mcand_q : '0;
    if (last_i && sgn_q) begin
      sum_d = acc_q - pp;
    end else begin
      sum_d = acc_q + pp;
    end
  end

  assign prod_next_o = sum_d;

  always_ff @(posedge clk) begin
    if (load_i) begin
      mcand_q  <= extend(a_i, sgn_i);
      mplier_q <= b_i;
      acc_q    <= '0;
      sgn_q    <= sgn_i;
    end else if (step_i) begin
      acc_q    <= sum_d;
      mcand_q  <= {mcand_q[2*BITS-2:0], 1'b0};
      mplier_q <= {1'b0, mplier_q[BITS-1:1]};
    end
  end

endmodule

// File: rtl/seq_mult.sv
// Sequential multiplier: capture operands in IDLE, BITS-cycle RUN, hold result in DONE.
module seq_mult
  import seq_mult_pkg::*;
#(
  parameter int BITS = BITS_DEFAULT
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic [BITS-1:0]   A,
  input  logic [BITS-1:0]   B,
  input  logic              IEA,
  input  logic              IEB,
  input  logic              SGN,
  input  logic              ACC,
  output logic [2*BITS-1:0] Y,
  output logic              OE,
  output logic              BUSY
);

  localparam int CW = $clog2(BITS) + 1;

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              a_ok_q, a_ok_d;
  logic              b_ok_q, b_ok_d;
  logic [2*BITS-1:0] y_q, y_d;
  logic [BITS-1:0]   a_q, a_d;
  logic [BITS-1:0]   b_q, b_d;
  logic              acc_mode_q, acc_mode_d;
  logic              start;
  logic              last;
  logic [2*BITS-1:0] prod_next;

  // An enable seen on the start edge itself counts as a capture.
  assign start = (state_q == IDLE) && (a_ok_q || IEA) && (b_ok_q || IEB);
  assign last  = (cnt_q == CW'(BITS - 1));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    a_ok_d     = a_ok_q;
    b_ok_d     = b_ok_q;
    y_d        = y_q;
    a_d        = a_q;
    b_d        = b_q;
    acc_mode_d = acc_mode_q;
    case (state_q)
      IDLE: begin
        if (IEA) begin
          a_ok_d = 1'b1;
          a_d    = A;
        end
        if (IEB) begin
          b_ok_d = 1'b1;
          b_d    = B;
        end
        if (start) begin
          state_d    = RUN;
          cnt_d      = '0;
          acc_mode_d = ACC;
        end
      end
      RUN: begin
        if (last) begin
          state_d = DONE;
          cnt_d   = '0;
          y_d     = acc_mode_q ? (y_q + prod_next) : prod_next;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE: begin
        if (!IEB) begin
          state_d = IDLE;
          a_ok_d  = 1'b0;
          b_ok_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      a_ok_q  <= 1'b0;
      b_ok_q  <= 1'b0;
      y_q     <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_ok_q  <= a_ok_d;
      b_ok_q  <= b_ok_d;
      y_q     <= y_d;
    end
  end

  // Operand holding registers are only meaningful behind a_ok/b_ok, so no reset.
  always_ff @(posedge CLK) begin
    a_q        <= a_d;
    b_q        <= b_d;
    acc_mode_q <= acc_mode_d;
  end

  seq_mult_dp #(
    .BITS(BITS)
  ) u_dp (
    .clk        (CLK),
    .load_i     (start),
    .step_i     (state_q == RUN),
    .last_i     (last),
    .sgn_i      (SGN),
    .a_i        (a_d),
    .b_i        (b_d),
    .prod_next_o(prod_next)
  );

  assign Y    = y_q;
  assign OE   = (state_q == DONE);
  assign BUSY = (state_q == RUN);

endmodule

// File: tb/tb_seq_mult.sv
// Self-checking bench for seq_mult (BITS=8): vector table, scoreboard queue, corner sequences.
module tb_seq_mult;

  localparam int BITS = 8;

  logic            CLK = 1'b0;
  logic            RSTN;
  logic [BITS-1:0] A, B;
  logic            IEA, IEB, SGN, ACC;
  logic [2*BITS-1:0] Y;
  logic            OE, BUSY;

  int checks = 0;
  int errors = 0;
  logic [2*BITS-1:0] exp_q[$];
  logic [2*BITS-1:0] y_model = '0;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sgn;
    logic        acc;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[$];

  seq_mult #(.BITS(BITS)) dut (
    .CLK (CLK), .RSTN(RSTN), .A(A), .B(B), .IEA(IEA), .IEB(IEB),
    .SGN (SGN), .ACC(ACC), .Y(Y), .OE(OE), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Waits for OE after a start edge; drops IEA / scrambles inputs from cycle 2 when asked.
  task automatic wait_result(input string name, input bit scramble);
    int n;
    bit seen;
    logic [15:0] e;
    n = 0;
    seen = 1'b0;
    while (n < BITS + 12 && !seen) begin
      if (scramble && n == 2) begin
        IEA = 1'b0;
        A = 8'($urandom);
        B = 8'($urandom);
        SGN = 1'($urandom);
        ACC = 1'($urandom);
      end
      @(posedge CLK);
      #1;
      n++;
      if (OE) seen = 1'b1;
    end
    if (!seen) begin
      check({name, "_oe_timeout"}, 32'(seen), 32'd1);
    end else begin
      check({name, "_latency"}, 32'(n), 32'(BITS));
      check({name, "_busy_done"}, 32'(BUSY), 32'd0);
      if (exp_q.size() == 0) begin
        check({name, "_sb_empty"}, 32'(exp_q.size()), 32'd1);
      end else begin
        e = exp_q.pop_front();
        check({name, "_y"}, 32'(Y), 32'(e));
      end
    end
  endtask

  task automatic run_op(input string name, input logic [7:0] a, input logic [7:0] b,
                        input logic sgn, input logic acc, input logic [15:0] exp);
    logic [15:0] yk;
    @(negedge CLK);
    A = a; B = b; SGN = sgn; ACC = acc; IEA = 1'b1; IEB = 1'b1;
    exp_q.push_back(exp);
    y_model = exp;
    @(posedge CLK);
    #1;
    check({name, "_busy_start"}, 32'(BUSY), 32'd1);
    wait_result(name, 1'b1);
    yk = Y;
    IEA = 1'($urandom);
    A = 8'($urandom);
    B = 8'($urandom);
    @(posedge CLK);
    #1;
    check({name, "_oe_hold"}, 32'(OE), 32'd1);
    check({name, "_y_hold"}, 32'(Y), 32'(yk));
    IEA = 1'b0;
    IEB = 1'b0;
    @(posedge CLK);
    #1;
    check({name, "_oe_drop"}, 32'(OE), 32'd0);
    check({name, "_y_idle"}, 32'(Y), 32'(yk));
  endtask

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic sgn, input logic acc, input logic [15:0] yp);
    logic signed [15:0] sa, sb;
    logic [15:0] p;
    sa = $signed(a);
    sb = $signed(b);
    p = sgn ? 16'(sa * sb) : ({8'd0, a} * {8'd0, b});
    return acc ? 16'(yp + p) : p;
  endfunction

  initial begin
    logic [7:0] ra, rb;
    logic rs, rc;
    logic [15:0] re;

    RSTN = 1'b0; A = '0; B = '0; IEA = 0; IEB = 0; SGN = 0; ACC = 0;
    #1;
    check("rst_y", 32'(Y), 32'd0);
    check("rst_oe", 32'(OE), 32'd0);
    check("rst_busy", 32'(BUSY), 32'd0);
    repeat (2) @(negedge CLK);
    RSTN = 1'b1;

    for (int i = 0; i < 6; i++) vecs.push_back('{8'(i), 8'(i), 1'b0, 1'b0, 16'(i * i)});
    vecs.push_back('{8'h80, 8'h80, 1'b1, 1'b0, 16'h4000});
    vecs.push_back('{8'hFF, 8'h03, 1'b1, 1'b0, 16'hFFFD});
    vecs.push_back('{8'h80, 8'h7F, 1'b1, 1'b0, 16'hC080});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 1'b0, 16'hFE01});
    vecs.push_back('{8'h00, 8'h00, 1'b0, 1'b0, 16'h0000});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFE01});
    vecs.push_back('{8'hFF, 8'hFF, 1'b0, 1'b1, 16'hFC02});
    vecs.push_back('{8'h7F, 8'h7F, 1'b1, 1'b1, 16'h3B03});

    for (int i = 0; i < vecs.size(); i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].sgn, vecs[i].acc, vecs[i].exp);
    end

    // Split enables: A at cycle 0, B at cycle 5; IEB already low when DONE is entered.
    @(negedge CLK);
    A = 8'd7; IEA = 1'b1; SGN = 1'b0; ACC = 1'b0;
    @(negedge CLK);
    IEA = 1'b0; A = 8'd99;
    for (int c = 1; c < 5; c++) begin
      @(posedge CLK);
      #1;
      check("split_wait_busy", 32'(BUSY), 32'd0);
      @(negedge CLK);
    end
    B = 8'd9; IEB = 1'b1;
    exp_q.push_back(16'd63);
    @(posedge CLK);
    #1;
    check("split_busy_start", 32'(BUSY), 32'd1);
    @(negedge CLK);
    IEB = 1'b0; B = 8'd200;
    wait_result("split", 1'b0);
    @(posedge CLK);
    #1;
    check("split_oe_one_cycle", 32'(OE), 32'd0);

    // Flags cleared on DONE exit: a lone B must not start; a later A completes it.
    @(negedge CLK);
    B = 8'd5; IEB = 1'b1;
    @(posedge CLK);
    #1;
    check("flag_b_only", 32'(BUSY), 32'd0);
    @(negedge CLK);
    IEB = 1'b0; B = 8'd77;
    @(posedge CLK);
    #1;
    check("flag_b_only2", 32'(BUSY), 32'd0);
    @(negedge CLK);
    A = 8'd2; IEA = 1'b1;
    exp_q.push_back(16'd10);
    @(posedge CLK);
    #1;
    check("flag_start", 32'(BUSY), 32'd1);
    @(negedge CLK);
    IEA = 1'b0;
    wait_result("flag", 1'b0);
    @(posedge CLK);
    #1;
    check("flag_oe_drop", 32'(OE), 32'd0);

    // Asynchronous reset in the middle of RUN.
    @(negedge CLK);
    A = 8'd100; B = 8'd100; IEA = 1'b1; IEB = 1'b1;
    @(negedge CLK);
    IEA = 1'b0; IEB = 1'b0;
    repeat (3) @(posedge CLK);
    #2;
    RSTN = 1'b0;
    #1;
    check("rst_mid_y", 32'(Y), 32'd0);
    check("rst_mid_oe", 32'(OE), 32'd0);
    check("rst_mid_busy", 32'(BUSY), 32'd0);
    @(negedge CLK);
    RSTN = 1'b1;
    repeat (2) begin
      @(posedge CLK);
      #1;
      check("rst_release_idle", 32'(BUSY), 32'd0);
    end
    run_op("post_rst", 8'd3, 8'd4, 1'b0, 1'b0, 16'd12);

    for (int i = 0; i < 8; i++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rs = 1'($urandom);
      rc = 1'($urandom);
      re = model(ra, rb, rs, rc, y_model);
      run_op($sformatf("rnd%0d", i), ra, rb, rs, rc, re);
    end

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult.md
SEQ_MULT -- requirements
Module: seq_mult

Interface
REQ-001 Parameter BITS, default 8, operand width; legal range BITS >= 2.
REQ-002 CLK  input  1  single clock; all state changes on rising edge.
REQ-003 RSTN  input  1  reset, asynchronous, active-low.
REQ-004 A  input  BITS  multiplicand, captured under IEA.
REQ-005 B  input  BITS  multiplier, captured under IEB.
REQ-006 IEA  input  1  input enable for A.
REQ-007 IEB  input  1  input enable for B; also holds the result handshake open.
REQ-008 SGN  input  1  mode: 1 = two's-complement signed, 0 = unsigned.
REQ-009 ACC  input  1  mode: 1 = accumulate the product into Y, 0 = overwrite Y.
REQ-010 Y  output  2*BITS  result register.
REQ-011 OE  output  1  result valid.
REQ-012 BUSY  output  1  high while in RUN.

Function
REQ-013 The FSM SHALL have states IDLE, RUN and DONE.
REQ-014 In IDLE, each edge with IEA=1 SHALL capture A and set flag a_ok; each edge with IEB=1 SHALL capture B and set flag b_ok; a later capture overwrites an earlier one.
REQ-015 IDLE->RUN SHALL occur on the edge where (a_ok|IEA)&(b_ok|IEB) is true; A, B, SGN and ACC are captured on that same edge.
REQ-016 RUN SHALL last exactly BITS cycles, counted by a cycle counter of width clog2(BITS)+1; zero operands do not shorten it.
REQ-017 RUN->DONE SHALL load Y with P (ACC=0) or with (Y+P) mod 2^(2*BITS) (ACC=1); P is the exact 2*BITS-bit product under SGN.
REQ-018 OE SHALL be 1 exactly while in DONE; BUSY SHALL be 1 exactly while in RUN.
REQ-019 DONE->IDLE SHALL occur on the first edge with IEB=0; a_ok and b_ok clear on that edge, and OE is high for at least one cycle.
REQ-020 IEA, IEB, A, B, SGN and ACC SHALL be ignored in RUN, and in DONE except for the IEB exit condition.
REQ-021 Y SHALL hold its value outside the RUN->DONE edge, so the last result remains readable in IDLE.
REQ-022 Signed boundary: with BITS=8 and SGN=1, -128*-128 SHALL yield 16384 and -128*127 SHALL yield -16256.
REQ-023 Unsigned boundary: with BITS=8 and SGN=0, 255*255 SHALL yield 65025.
REQ-024 ACC wrap-around SHALL be silent modulo 2^(2*BITS), with no overflow flag.

Reset
REQ-025 RSTN=0 SHALL immediately force IDLE, Y=0, OE=0, BUSY=0, counter=0, a_ok=b_ok=0, independent of CLK.
REQ-026 Reset in RUN or DONE SHALL abort the operation with no Y update; the first post-reset operation behaves as from power-up.
REQ-027 Deassertion of RSTN SHALL NOT by itself start an operation; REQ-015 applies from the next edge.

Structure
REQ-028 Package seq_mult_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default BITS constant.
REQ-029 Datapath sub-module seq_mult_dp SHALL implement a shift-add accumulator, one partial product per RUN cycle, with sign correction for SGN=1 (negated last partial product or Booth).
REQ-030 There SHALL be no combinational path from inputs to Y or OE.

Verification
REQ-031 BITS=8, SGN=0, ACC=0; for i=0..5: IEA=IEB=1 with A=B=i, drop IEA after 2 cycles, wait OE -> Y=i*i with OE exactly 8 cycles after the start edge; drop IEB -> OE=0 one cycle later.
REQ-032 SGN=1: A=8'h80, B=8'h80 -> Y=16'h4000; A=8'hFF, B=8'h03 -> Y=16'hFFFD.
REQ-033 ACC=1 sequence 255*255 then 255*255, starting from Y=0 -> Y=65025, then Y=(130050 mod 65536)=64514.
REQ-034 Split enables: IEA pulsed at cycle 0 with A=7, IEB pulsed at cycle 5 with B=9 -> RUN starts on the cycle-5 edge, Y=63.
REQ-035 RSTN pulsed low mid-RUN -> OE=0, BUSY=0, Y=0 immediately; the next 3*4 operation gives Y=12.
REQ-036 Change A, B and IEA during RUN and DONE -> result unchanged; IEB already 0 on DONE entry -> OE high for exactly one cycle.
